// File: rtl/state_seq_gen.sv
// Parametrised state walker: steps a registered state code through N_STATES
// ordered states with stop / wrap / bounce / hold end-of-range behaviour.
module state_seq_gen #(
    parameter int N_STATES = 4,
    parameter int CNT_W    = 8,
    localparam int W       = (N_STATES > 2) ? $clog2(N_STATES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             load,
    input  logic [W-1:0]     load_val,
    output logic [W-1:0]     state,
    output logic [W-1:0]     state_prev,
    output logic             changed,
    output logic             wrap,
    output logic             done,
    output logic             at_first,
    output logic             at_last,
    output logic [CNT_W-1:0] step_cnt
);

    typedef enum logic [1:0] {
        MODE_STOP   = 2'd0,
        MODE_WRAP   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_e;

    localparam logic [W-1:0] LAST        = W'(N_STATES - 1);
    localparam logic [W-1:0] BOUNCE_BACK = W'(N_STATES - 2);

    mode_e            mode_s;
    logic [W-1:0]     state_q, state_d;
    logic [W-1:0]     prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             changed_q, changed_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic             bdir_q, bdir_d;
    logic             is_first, is_last;
    logic [W-1:0]     fwd, bwd, target, load_clamped;

    assign mode_s   = mode_e'(mode);
    assign is_first = (state_q == '0);
    assign is_last  = (state_q == LAST);
    assign fwd      = state_q + W'(1);
    assign bwd      = state_q - W'(1);

    // Clamping is only needed when the code space exceeds the state count.
    generate
        if ((1 << W) == N_STATES) begin : g_no_clamp
            assign load_clamped = load_val;
        end else begin : g_clamp
            assign load_clamped = (load_val > LAST) ? LAST : load_val;
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        cnt_d     = cnt_q;
        changed_d = 1'b0;
        wrap_d    = 1'b0;
        done_d    = done_q;
        bdir_d    = bdir_q;
        target    = state_q;
        if (load) begin
            state_d = load_clamped;
            bdir_d  = dir;
            done_d  = 1'b0;
            if (load_clamped != state_q) begin
                changed_d = 1'b1;
                prev_d    = state_q;
            end
        end else if (en) begin
            case (mode_s)
                MODE_STOP: begin
                    if (!dir) begin
                        if (is_last) done_d = 1'b1;
                        else         target = fwd;
                    end else begin
                        if (is_first) done_d = 1'b1;
                        else          target = bwd;
                    end
                end
                MODE_WRAP: begin
                    if (!dir) begin
                        target = is_last ? '0 : fwd;
                        wrap_d = is_last;
                    end else begin
                        target = is_first ? LAST : bwd;
                        wrap_d = is_first;
                    end
                end
                MODE_BOUNCE: begin
                    if (!bdir_q) begin
                        if (is_last) begin
                            target = BOUNCE_BACK;
                            bdir_d = 1'b1;
                            wrap_d = 1'b1;
                        end else begin
                            target = fwd;
                        end
                    end else begin
                        if (is_first) begin
                            target = W'(1);
                            bdir_d = 1'b0;
                            wrap_d = 1'b1;
                        end else begin
                            target = bwd;
                        end
                    end
                end
                default: ;
            endcase
            // A refused STOP step or HOLD leaves target equal to state_q.
            if (target != state_q) begin
                state_d   = target;
                prev_d    = state_q;
                changed_d = 1'b1;
                if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= '0;
            prev_q    <= '0;
            cnt_q     <= '0;
            changed_q <= 1'b0;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
            bdir_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            changed_q <= changed_d;
            wrap_q    <= wrap_d;
            done_q    <= done_d;
            bdir_q    <= bdir_d;
        end
    end

    assign state      = state_q;
    assign state_prev = prev_q;
    assign changed    = changed_q;
    assign wrap       = wrap_q;
    assign done       = done_q;
    assign step_cnt   = cnt_q;
    assign at_first   = is_first;
    assign at_last    = is_last;

endmodule

// File: tb/tb_state_seq_gen.sv
// Bench for state_seq_gen: three instances (N=4/CNT_W=3, N=5/CNT_W=8, N=2/CNT_W=4)
// share stimulus and are compared every cycle against an arithmetic model.
module tb_state_seq_gen;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, en = 1'b0, dir = 1'b0, load = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [2:0] lv3 = 3'd0;

    logic [1:0] a_state, a_prev;
    logic       a_chg, a_wrap, a_done, a_first, a_last;
    logic [2:0] a_cnt;
    logic [2:0] b_state, b_prev;
    logic       b_chg, b_wrap, b_done, b_first, b_last;
    logic [7:0] b_cnt;
    logic [0:0] c_state, c_prev;
    logic       c_chg, c_wrap, c_done, c_first, c_last;
    logic [3:0] c_cnt;

    state_seq_gen #(.N_STATES(4), .CNT_W(3)) u_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
        .load_val(lv3[1:0]), .state(a_state), .state_prev(a_prev), .changed(a_chg),
        .wrap(a_wrap), .done(a_done), .at_first(a_first), .at_last(a_last), .step_cnt(a_cnt));

    state_seq_gen #(.N_STATES(5), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
        .load_val(lv3), .state(b_state), .state_prev(b_prev), .changed(b_chg),
        .wrap(b_wrap), .done(b_done), .at_first(b_first), .at_last(b_last), .step_cnt(b_cnt));

    state_seq_gen #(.N_STATES(2), .CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
        .load_val(lv3[0:0]), .state(c_state), .state_prev(c_prev), .changed(c_chg),
        .wrap(c_wrap), .done(c_done), .at_first(c_first), .at_last(c_last), .step_cnt(c_cnt));

    // observed outputs gathered per instance
    int o_state[3], o_prev[3], o_cnt[3], o_chg[3], o_wrap[3], o_done[3], o_first[3], o_last[3];
    always_comb begin
        o_state[0] = int'(a_state); o_prev[0] = int'(a_prev); o_cnt[0] = int'(a_cnt);
        o_chg[0] = int'(a_chg); o_wrap[0] = int'(a_wrap); o_done[0] = int'(a_done);
        o_first[0] = int'(a_first); o_last[0] = int'(a_last);
        o_state[1] = int'(b_state); o_prev[1] = int'(b_prev); o_cnt[1] = int'(b_cnt);
        o_chg[1] = int'(b_chg); o_wrap[1] = int'(b_wrap); o_done[1] = int'(b_done);
        o_first[1] = int'(b_first); o_last[1] = int'(b_last);
        o_state[2] = int'(c_state); o_prev[2] = int'(c_prev); o_cnt[2] = int'(c_cnt);
        o_chg[2] = int'(c_chg); o_wrap[2] = int'(c_wrap); o_done[2] = int'(c_done);
        o_first[2] = int'(c_first); o_last[2] = int'(c_last);
    end

    // reference model
    int    ns[3]   = '{4, 5, 2};
    int    wd[3]   = '{2, 3, 1};
    int    cmax[3] = '{7, 255, 15};
    string nm[3]   = '{"a", "b", "c"};
    int m_state[3], m_prev[3], m_cnt[3], m_chg[3], m_wrap[3], m_done[3], m_bdir[3];
    logic [1:0] exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input int k);
        int n, s, nxt, lv, wr;
        n = ns[k]; s = m_state[k]; nxt = s; wr = 0;
        if (rst) begin
            m_state[k] = 0; m_prev[k] = 0; m_cnt[k] = 0;
            m_chg[k] = 0; m_wrap[k] = 0; m_done[k] = 0; m_bdir[k] = 0;
        end else if (load) begin
            lv = int'(lv3) % (1 << wd[k]);
            if (lv > n - 1) lv = n - 1;
            m_bdir[k] = int'(dir); m_done[k] = 0; m_wrap[k] = 0;
            m_chg[k] = (lv != s) ? 1 : 0;
            if (lv != s) m_prev[k] = s;
            m_state[k] = lv;
        end else if (en) begin
            case (mode)
                2'd0: begin
                    if (dir == 1'b0) begin
                        if (s == n - 1) m_done[k] = 1; else nxt = s + 1;
                    end else begin
                        if (s == 0) m_done[k] = 1; else nxt = s - 1;
                    end
                end
                2'd1: begin
                    if (dir == 1'b0) begin nxt = (s + 1) % n; wr = (s == n - 1) ? 1 : 0; end
                    else begin nxt = (s + n - 1) % n; wr = (s == 0) ? 1 : 0; end
                end
                2'd2: begin
                    if (m_bdir[k] == 0) begin
                        if (s == n - 1) begin m_bdir[k] = 1; nxt = n - 2; wr = 1; end
                        else nxt = s + 1;
                    end else begin
                        if (s == 0) begin m_bdir[k] = 0; nxt = 1; wr = 1; end
                        else nxt = s - 1;
                    end
                end
                default: ;
            endcase
            m_wrap[k] = wr;
            m_chg[k] = (nxt != s) ? 1 : 0;
            if (nxt != s) begin
                m_prev[k] = s; m_state[k] = nxt;
                if (m_cnt[k] < cmax[k]) m_cnt[k]++;
            end
        end else begin
            m_chg[k] = 0; m_wrap[k] = 0;
        end
        if (k == 0) exp_q.push_back(2'(m_state[0]));
    endtask

    task automatic check_all();
        logic [1:0] exp_a;
        for (int k = 0; k < 3; k++) begin
            if (k == 0) begin
                exp_a = exp_q.pop_front();
                check("a.state", o_state[0], int'(exp_a));
            end else begin
                check({nm[k], ".state"}, o_state[k], m_state[k]);
            end
            check({nm[k], ".state_prev"}, o_prev[k], m_prev[k]);
            check({nm[k], ".step_cnt"}, o_cnt[k], m_cnt[k]);
            check({nm[k], ".changed"}, o_chg[k], m_chg[k]);
            check({nm[k], ".wrap"}, o_wrap[k], m_wrap[k]);
            check({nm[k], ".done"}, o_done[k], m_done[k]);
            check({nm[k], ".at_first"}, o_first[k], (m_state[k] == 0) ? 1 : 0);
            check({nm[k], ".at_last"}, o_last[k], (m_state[k] == ns[k] - 1) ? 1 : 0);
        end
    endtask

    // driver: apply inputs away from the edge, update model at the edge, sample 1ns later
    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic d, input logic l, input logic [2:0] v);
        @(negedge clk);
        rst = r; en = e; mode = m; dir = d; load = l; lv3 = v;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_edge(k);
        #1;
        check_all();
    endtask

    int stop_seq[5]   = '{1, 2, 3, 3, 3};
    int bounce_seq[8] = '{1, 2, 3, 2, 1, 0, 1, 2};
    int wrapb_seq[3]  = '{4, 3, 2};
    int wrapb_pls[3]  = '{1, 0, 0};
    int pulses;

    initial begin
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0);
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0);
        check("reset a.state", o_state[0], 0);
        check("reset a.at_first", o_first[0], 1);

        // STOP walk forward on N=4
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 3'd0);
            check("stop a.state", o_state[0], stop_seq[i]);
            pulses += o_chg[0];
            if (i >= 2) check("stop a.at_last", o_last[0], 1);
            if (i == 3) check("stop a.done", o_done[0], 1);
        end
        check("stop a.changed pulses", pulses, 3);
        check("stop a.step_cnt", o_cnt[0], 3);

        // WRAP backward on N=5
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 3'd0);
            check("wrapb b.state", o_state[1], wrapb_seq[i]);
            check("wrapb b.wrap", o_wrap[1], wrapb_pls[i]);
        end
        check("wrapb b.state_prev", o_prev[1], 3);

        // BOUNCE on N=4
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 3'd0);
            check("bounce a.state", o_state[0], bounce_seq[i]);
            check("bounce a.wrap", o_wrap[0], (i == 3 || i == 6) ? 1 : 0);
        end

        // load clamp and priority over en
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0);
        step(1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 3'd0);
        step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 3'd0);
        check("preload a.done", o_done[0], 1);
        step(1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 3'd7);
        check("load a.state", o_state[0], 3);
        check("load b.state clamp", o_state[1], 4);
        check("load a.done", o_done[0], 0);
        check("load a.changed", o_chg[0], 1);
        check("load a.state_prev", o_prev[0], 1);
        check("load a.step_cnt", o_cnt[0], 1);

        // reset mid-run with en and load
        step(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 3'd0);
        step(1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 3'd2);
        check("rstmid a.state", o_state[0], 0);
        check("rstmid a.step_cnt", o_cnt[0], 0);
        check("rstmid a.at_first", o_first[0], 1);

        // saturation then HOLD
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 3'd0);
        check("sat a.step_cnt", o_cnt[0], 7);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 3'd0);
            check("hold a.state", o_state[0], 2);
            check("hold a.changed", o_chg[0], 0);
        end

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
                 3'($urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
